// File: rtl/mem_pkg.sv
// Shared types and helpers for the program-memory responder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int CNT_W      = 16;

  // Top-level sequencing: image load, CPU run, post-run readback.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } mem_state_t;

  // Decoded CPU strobe set for one cycle.
  typedef struct packed {
    logic rd_ok;
    logic wr_ok;
    logic proto_err;
  } cpu_cmd_t;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    logic [CNT_W-1:0] r;
    r = v;
    if (en && (v != {CNT_W{1'b1}})) begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Classify the CPU strobes. Only a clean single read or single write in
  // ST_RUN is accepted; any other strobe pattern, or any strobe at all while
  // the CPU should be idle (load / halt), is a protocol error.
  function automatic cpu_cmd_t decode_cpu(input mem_state_t st,
                                          input logic       en,
                                          input logic       rd,
                                          input logic       wr);
    cpu_cmd_t c;
    c = '0;
    if (st == ST_RUN) begin
      c.rd_ok     = en & rd & ~wr;
      c.wr_ok     = en & wr & ~rd;
      c.proto_err = (en | rd | wr) & ~(c.rd_ok | c.wr_ok);
    end else begin
      c.proto_err = en | rd | wr;
    end
    return c;
  endfunction

endpackage

// File: rtl/mem_sp_ram.sv
// Word memory: one write port, two registered read ports (CPU, dump).
// Latency: write takes effect at the edge; reads return one cycle later.
// Backpressure: none; every enabled access is serviced in its cycle.
module mem_sp_ram
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [MEM_DATA_W-1:0] wr_data_i,
  input  logic                  cpu_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] cpu_rd_addr_i,
  output logic [MEM_DATA_W-1:0] cpu_rd_data_o,
  input  logic                  dump_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] dump_rd_addr_i,
  output logic [MEM_DATA_W-1:0] dump_rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage is deliberately left out of reset so a reset keeps the image.
  logic [MEM_DATA_W-1:0] mem_q [DEPTH];

  logic [MEM_DATA_W-1:0] cpu_rd_d,  cpu_rd_q;
  logic [MEM_DATA_W-1:0] dump_rd_d, dump_rd_q;

  // Array write: one word per cycle when enabled.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // CPU read data holds its last value until the next accepted read;
  // dump data reads as zero whenever the dump port is not enabled.
  always_comb begin
    cpu_rd_d = cpu_rd_q;
    if (cpu_rd_en_i) begin
      cpu_rd_d = mem_q[cpu_rd_addr_i];
    end
    dump_rd_d = '0;
    if (dump_rd_en_i) begin
      dump_rd_d = mem_q[dump_rd_addr_i];
    end
  end

  // Read output registers, cleared by reset (unlike the array).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cpu_rd_q  <= '0;
      dump_rd_q <= '0;
    end else begin
      cpu_rd_q  <= cpu_rd_d;
      dump_rd_q <= dump_rd_d;
    end
  end

  assign cpu_rd_data_o  = cpu_rd_q;
  assign dump_rd_data_o = dump_rd_q;

endmodule

// File: rtl/mem_responder.sv
// CPU program memory with image loader, run control, halt readback and stats.
// Latency: CPU read / dump data one cycle after request; writes land at the edge.
// Backpressure: none toward the CPU; loader may write only while load_ready_o=1.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // CPU port
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [MEM_DATA_W-1:0] mem_value_i,
  input  logic                  mem_enable_i,
  input  logic                  mem_wr_en_i,
  input  logic                  mem_rd_en_i,
  input  logic                  end_program_i,
  output logic [MEM_DATA_W-1:0] mem_value_o,
  output logic                  cpu_rst_o,
  // Program-image loader
  input  logic                  load_valid_i,
  input  logic                  load_last_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [MEM_DATA_W-1:0] load_data_i,
  output logic                  load_ready_o,
  // Post-run readback
  input  logic [ADDR_WIDTH-1:0] dump_addr_i,
  output logic [MEM_DATA_W-1:0] dump_data_o,
  // Status
  output logic                  halted_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      rd_count_o,
  output logic [CNT_W-1:0]      wr_count_o
);

  mem_state_t state_d, state_q;

  logic             err_d,    err_q;
  logic [CNT_W-1:0] rd_cnt_d, rd_cnt_q;
  logic [CNT_W-1:0] wr_cnt_d, wr_cnt_q;

  cpu_cmd_t cmd;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [MEM_DATA_W-1:0] ram_wdata;
  logic                  ram_cpu_re;
  logic                  ram_dump_re;

  // Classify this cycle's CPU strobes against the current state.
  always_comb begin
    cmd = decode_cpu(state_q, mem_enable_i, mem_rd_en_i, mem_wr_en_i);
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: last loaded word starts the CPU, end_program halts it,
  // and only reset leaves halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (load_valid_i && load_last_i) state_d = ST_RUN;
      ST_RUN:  if (end_program_i)               state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_LOAD;
    endcase
  end

  // FSM outputs: CPU held in reset only while the image is being loaded.
  always_comb begin
    cpu_rst_o    = (state_q == ST_LOAD);
    load_ready_o = (state_q == ST_LOAD);
    halted_o     = (state_q == ST_HALT);
  end

  // Write-port arbitration: loader owns it in load, CPU in run, nobody in
  // halt. Reset blocks any write presented in the same cycle.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = mem_addr_i;
    ram_wdata = mem_value_i;
    case (state_q)
      ST_LOAD: begin
        ram_we    = load_valid_i;
        ram_waddr = load_addr_i;
        ram_wdata = load_data_i;
      end
      ST_RUN:  ram_we = cmd.wr_ok;
      default: ram_we = 1'b0;
    endcase
    if (rst_i) begin
      ram_we = 1'b0;
    end
    ram_cpu_re  = cmd.rd_ok & ~rst_i;
    ram_dump_re = (state_q == ST_HALT) & ~rst_i;
  end

  // Sticky error flag and saturating access counters.
  always_comb begin
    err_d    = err_q | cmd.proto_err;
    rd_cnt_d = sat_inc(rd_cnt_q, cmd.rd_ok);
    wr_cnt_d = sat_inc(wr_cnt_q, cmd.wr_ok);
  end

  // Status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  mem_sp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wr_en_i        (ram_we),
    .wr_addr_i      (ram_waddr),
    .wr_data_i      (ram_wdata),
    .cpu_rd_en_i    (ram_cpu_re),
    .cpu_rd_addr_i  (mem_addr_i),
    .cpu_rd_data_o  (mem_value_o),
    .dump_rd_en_i   (ram_dump_re),
    .dump_rd_addr_i (dump_addr_i),
    .dump_rd_data_o (dump_data_o)
  );

  assign err_o      = err_q;
  assign rd_count_o = rd_cnt_q;
  assign wr_count_o = wr_cnt_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, word-address width; depth = 2**ADDR_WIDTH 16-bit words.
REQ-002 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 mem_addr_i  in  ADDR_WIDTH  CPU word address.
REQ-005 mem_value_i  in  16  CPU write data.
REQ-006 mem_enable_i  in  1  CPU access strobe (= wr_en OR rd_en).
REQ-007 mem_wr_en_i / mem_rd_en_i  in  1 each  CPU write / read request.
REQ-008 end_program_i  in  1  CPU program-end flag.
REQ-009 mem_value_o  out  16  CPU read data.
REQ-010 cpu_rst_o  out  1  holds CPU in reset while loading.
REQ-011 load_valid_i, load_last_i  in  1 each; load_addr_i  in  ADDR_WIDTH; load_data_i  in  16  program-image loader.
REQ-012 load_ready_o  out  1  loader may write.
REQ-013 dump_addr_i  in  ADDR_WIDTH; dump_data_o  out  16  post-run readback.
REQ-014 halted_o  out  1; err_o  out  1 sticky protocol error; rd_count_o, wr_count_o  out  16 each.

Function
REQ-015 FSM states ST_LOAD, ST_RUN, ST_HALT; after reset state = ST_LOAD.
REQ-016 ST_LOAD: cpu_rst_o=1, load_ready_o=1; load_valid_i writes load_data_i to load_addr_i at that edge.
REQ-017 ST_LOAD -> ST_RUN on edge with load_valid_i=1 and load_last_i=1 (that word is written); load_last_i without load_valid_i ignored.
REQ-018 ST_RUN: cpu_rst_o=0, load_ready_o=0; loader inputs ignored.
REQ-019 ST_RUN read: mem_enable_i=1, mem_rd_en_i=1, mem_wr_en_i=0 -> mem_value_o = mem[mem_addr_i] on the cycle after the request (1-cycle latency), held until next accepted read.
REQ-020 ST_RUN write: mem_enable_i=1, mem_wr_en_i=1, mem_rd_en_i=0 -> mem[mem_addr_i] = mem_value_i at that edge; mem_value_o unchanged.
REQ-021 Read of address written on previous cycle returns the new value; read-after-write same-address same-cycle impossible (single port).
REQ-022 Protocol errors set err_o (sticky until reset), no memory update: rd and wr both 1; enable=1 with neither; rd/wr=1 with enable=0; any CPU access in ST_LOAD or ST_HALT.
REQ-023 rd_count_o / wr_count_o increment once per accepted read/write, saturate at 16'hFFFF.
REQ-024 ST_RUN -> ST_HALT on edge with end_program_i=1; an accepted access on that same edge completes.
REQ-025 ST_HALT: halted_o=1, cpu_rst_o=0, memory frozen, ST_HALT exits only by reset.
REQ-026 dump_data_o = mem[dump_addr_i] one cycle after dump_addr_i, valid in ST_HALT only; else 16'h0000.
REQ-027 Address wrap: none needed; all ADDR_WIDTH values valid, no out-of-range case.

Reset
REQ-028 On rst_i=1: state=ST_LOAD, cpu_rst_o=1, load_ready_o=1, halted_o=0, err_o=0, counters=0, mem_value_o=0, dump_data_o=0.
REQ-029 Memory array NOT cleared by reset; reset mid-run or mid-load keeps written contents.
REQ-030 Reset has priority over every simultaneous event.

Structure
REQ-031 Shared package mem_pkg holds state enum mem_state_t, MEM_DATA_W=16, counter width constant.
REQ-032 Storage in sub-module mem_sp_ram (one write port, two registered read ports: CPU, dump); FSM, arbitration, counters, error logic in mem_responder.

Verification
REQ-033 Load 0x00=0x1234, 0x01=0xBEEF (last) -> ST_RUN next cycle, cpu_rst_o falls; CPU read 0x01 -> mem_value_o=0xBEEF one cycle later, rd_count_o=1.
REQ-034 RUN: write 0x7F=0xA5A5, next cycle read 0x7F -> 0xA5A5; wr_count_o=1, rd_count_o=1.
REQ-035 RUN: rd_en=wr_en=1 at 0x10 -> err_o=1 stays 1, mem[0x10] unchanged, counters unchanged.
REQ-036 RUN: write 0x20=0x0042 with end_program_i=1 same edge -> halted_o=1; dump_addr_i=0x20 -> dump_data_o=0x0042 one cycle later; later CPU writes ignored, err_o=1.
REQ-037 Pulse rst_i in ST_RUN -> ST_LOAD, all outputs at reset values, re-run read 0x00 returns 0x1234 after load_last.
REQ-038 65 536 accepted reads -> rd_count_o=16'hFFFF, no wrap.
